// File: rtl/shell_hit_checker.sv
// Shell collision checker: scans every shell once per frame against arena bounds, the wall map and the
// enemy tank, then issues one-cycle vanish/hit pulses and maintains lives and the game result.
module shell_hit_checker #(
  parameter int NUM_SHELL = 5,
  parameter int POS_W     = 6,
  parameter int MAP_W     = 40,
  parameter int MAP_H     = 30,
  parameter int LIVES     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       scan_start,
  input  logic [NUM_SHELL*POS_W-1:0] shell_1_x,
  input  logic [NUM_SHELL*POS_W-1:0] shell_1_y,
  input  logic [NUM_SHELL*POS_W-1:0] shell_2_x,
  input  logic [NUM_SHELL*POS_W-1:0] shell_2_y,
  input  logic [NUM_SHELL-1:0]       valid_1_shell,
  input  logic [NUM_SHELL-1:0]       valid_2_shell,
  input  logic [POS_W-1:0]           tank_1_x_pos,
  input  logic [POS_W-1:0]           tank_1_y_pos,
  input  logic [POS_W-1:0]           tank_2_x_pos,
  input  logic [POS_W-1:0]           tank_2_y_pos,
  output logic [10:0]                map_rd_addr,
  input  logic                       map_rd_data,
  output logic [NUM_SHELL-1:0]       vanish_1,
  output logic [NUM_SHELL-1:0]       vanish_2,
  output logic                       hit_1,
  output logic                       hit_2,
  output logic [1:0]                 lives_1,
  output logic [1:0]                 lives_2,
  output logic                       game_over,
  output logic [1:0]                 winner,
  output logic                       busy
);

  localparam logic [3:0] LAST_IDX = 4'(2*NUM_SHELL-1);

  typedef enum logic [1:0] {IDLE, ADDR, CHECK, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]           idx, sub_idx, sub_q;
  logic                 second, tank2_q, inflight_q;
  logic [POS_W-1:0]     cur_x, cur_y, ene_x, ene_y;
  logic                 cur_free;
  logic [POS_W-1:0]     x_q, y_q, ex_q, ey_q;
  logic [10:0]          addr_calc;
  logic [NUM_SHELL-1:0] pend_1, pend_2, kill_mask;
  logic                 phit_1, phit_2;
  logic                 oob, on_enemy, kill, enemy_hit;
  logic [1:0]           lives_1_nxt, lives_2_nxt;

  // Shell selection: first NUM_SHELL indices are tank-1 shells, the rest tank-2.
  always_comb begin
    second   = (idx >= 4'(NUM_SHELL));
    sub_idx  = second ? idx - 4'(NUM_SHELL) : idx;
    cur_x    = '0;
    cur_y    = '0;
    cur_free = 1'b1;
    for (int unsigned k = 0; k < NUM_SHELL; k++) begin
      if (sub_idx == 4'(k)) begin
        cur_x    = second ? shell_2_x[k*POS_W +: POS_W] : shell_1_x[k*POS_W +: POS_W];
        cur_y    = second ? shell_2_y[k*POS_W +: POS_W] : shell_1_y[k*POS_W +: POS_W];
        cur_free = second ? valid_2_shell[k] : valid_1_shell[k];
      end
    end
    ene_x = second ? tank_1_x_pos : tank_2_x_pos;
    ene_y = second ? tank_1_y_pos : tank_2_y_pos;
  end

  // 11-bit arithmetic equals the 12-bit product/sum truncated to 11 bits.
  assign addr_calc   = 11'(cur_y) * 11'(MAP_W) + 11'(cur_x);
  assign map_rd_addr = (state == ADDR) ? addr_calc : '0;

  always_comb begin
    oob       = (x_q >= POS_W'(MAP_W)) || (y_q >= POS_W'(MAP_H));
    on_enemy  = (x_q == ex_q) && (y_q == ey_q);
    kill      = inflight_q && (oob || map_rd_data || on_enemy);
    enemy_hit = inflight_q && !oob && !map_rd_data && on_enemy;
    kill_mask = '0;
    for (int unsigned k = 0; k < NUM_SHELL; k++)
      kill_mask[k] = kill && (sub_q == 4'(k));
  end

  always_comb begin
    lives_1_nxt = (phit_1 && lives_1 != '0) ? lives_1 - 2'd1 : lives_1;
    lives_2_nxt = (phit_2 && lives_2 != '0) ? lives_2 - 2'd1 : lives_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (scan_start && !game_over) state_nxt = ADDR;
      ADDR:  state_nxt = CHECK;
      CHECK: state_nxt = (idx == LAST_IDX) ? DONE : ADDR;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sub_q      <= '0;
      tank2_q    <= 1'b0;
      inflight_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      ex_q       <= '0;
      ey_q       <= '0;
      pend_1     <= '0;
      pend_2     <= '0;
      phit_1     <= 1'b0;
      phit_2     <= 1'b0;
      lives_1    <= 2'(LIVES);
      lives_2    <= 2'(LIVES);
      game_over  <= 1'b0;
      winner     <= '0;
    end else begin
      unique case (state)
        IDLE: if (scan_start && !game_over) begin
          idx    <= '0;
          pend_1 <= '0;
          pend_2 <= '0;
          phit_1 <= 1'b0;
          phit_2 <= 1'b0;
        end
        ADDR: begin
          sub_q      <= sub_idx;
          tank2_q    <= second;
          inflight_q <= !cur_free;
          x_q        <= cur_x;
          y_q        <= cur_y;
          ex_q       <= ene_x;
          ey_q       <= ene_y;
        end
        CHECK: begin
          idx <= idx + 4'd1;
          if (tank2_q) begin
            pend_2 <= pend_2 | kill_mask;
            if (enemy_hit) phit_1 <= 1'b1;
          end else begin
            pend_1 <= pend_1 | kill_mask;
            if (enemy_hit) phit_2 <= 1'b1;
          end
        end
        DONE: begin
          lives_1 <= lives_1_nxt;
          lives_2 <= lives_2_nxt;
          if (lives_1_nxt == '0 || lives_2_nxt == '0) begin
            game_over <= 1'b1;
            if (lives_1_nxt == '0 && lives_2_nxt == '0) winner <= 2'd3;
            else if (lives_1_nxt == '0)                  winner <= 2'd2;
            else                                         winner <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign vanish_1 = (state == DONE) ? pend_1 : '0;
  assign vanish_2 = (state == DONE) ? pend_2 : '0;
  assign hit_1    = (state == DONE) && phit_1;
  assign hit_2    = (state == DONE) && phit_2;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_shell_hit_checker.sv
// Randomized self-checking bench for shell_hit_checker against a per-shell rule model and a lives model.
module tb_shell_hit_checker;

  localparam int NS = 5;
  localparam int PW = 6;
  localparam int MW = 40;
  localparam int MH = 30;

  logic           clk, rst_n, scan_start;
  logic [NS*PW-1:0] shell_1_x, shell_1_y, shell_2_x, shell_2_y;
  logic [NS-1:0]  valid_1_shell, valid_2_shell;
  logic [PW-1:0]  tank_1_x_pos, tank_1_y_pos, tank_2_x_pos, tank_2_y_pos;
  logic [10:0]    map_rd_addr;
  logic           map_rd_data;
  logic [NS-1:0]  vanish_1, vanish_2;
  logic           hit_1, hit_2, game_over, busy;
  logic [1:0]     lives_1, lives_2, winner;

  logic map_mem [0:2047];
  int   tests_run, tests_failed;
  int   m_l1, m_l2, m_win;
  bit   m_go;

  shell_hit_checker #(.NUM_SHELL(NS), .POS_W(PW), .MAP_W(MW), .MAP_H(MH), .LIVES(3)) dut (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start),
    .shell_1_x(shell_1_x), .shell_1_y(shell_1_y), .shell_2_x(shell_2_x), .shell_2_y(shell_2_y),
    .valid_1_shell(valid_1_shell), .valid_2_shell(valid_2_shell),
    .tank_1_x_pos(tank_1_x_pos), .tank_1_y_pos(tank_1_y_pos),
    .tank_2_x_pos(tank_2_x_pos), .tank_2_y_pos(tank_2_y_pos),
    .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
    .vanish_1(vanish_1), .vanish_2(vanish_2), .hit_1(hit_1), .hit_2(hit_2),
    .lives_1(lives_1), .lives_2(lives_2), .game_over(game_over), .winner(winner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) map_rd_data <= map_mem[map_rd_addr];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map();
    for (int i = 0; i < 2048; i++) map_mem[i] = 1'b0;
  endtask

  task automatic park_shells();
    shell_1_x = '0; shell_1_y = '0; shell_2_x = '0; shell_2_y = '0;
    valid_1_shell = '1; valid_2_shell = '1;
    tank_1_x_pos = 6'd1; tank_1_y_pos = 6'd1;
    tank_2_x_pos = 6'd2; tank_2_y_pos = 6'd2;
  endtask

  task automatic set_shell(input int t, input int k, input int x, input int y, input bit inflight);
    if (t == 1) begin
      shell_1_x[k*PW +: PW] = PW'(x); shell_1_y[k*PW +: PW] = PW'(y); valid_1_shell[k] = !inflight;
    end else begin
      shell_2_x[k*PW +: PW] = PW'(x); shell_2_y[k*PW +: PW] = PW'(y); valid_2_shell[k] = !inflight;
    end
  endtask

  task automatic apply_reset();
    scan_start = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    m_l1 = 3; m_l2 = 3; m_go = 1'b0; m_win = 0;
    tick();
  endtask

  // Expected results come from the collision rules applied shell by shell.
  task automatic run_scan(input string name);
    logic [NS-1:0] ev1, ev2, gv1, gv2;
    bit eh1, eh2, gh1, gh2, window_ok;
    int x, y, ex, ey, nl1, nl2, nwin;
    bit inflight, ngo;
    ev1 = '0; ev2 = '0; eh1 = 0; eh2 = 0;
    for (int t = 1; t <= 2; t++) begin
      for (int k = 0; k < NS; k++) begin
        if (t == 1) begin
          x = int'(shell_1_x[k*PW +: PW]); y = int'(shell_1_y[k*PW +: PW]);
          inflight = !valid_1_shell[k]; ex = int'(tank_2_x_pos); ey = int'(tank_2_y_pos);
        end else begin
          x = int'(shell_2_x[k*PW +: PW]); y = int'(shell_2_y[k*PW +: PW]);
          inflight = !valid_2_shell[k]; ex = int'(tank_1_x_pos); ey = int'(tank_1_y_pos);
        end
        if (inflight) begin
          bit v, h;
          v = 0; h = 0;
          if (x >= MW || y >= MH)       v = 1;
          else if (map_mem[y*MW + x])   v = 1;
          else if (x == ex && y == ey) begin v = 1; h = 1; end
          if (t == 1) begin ev1[k] = v; if (h) eh2 = 1; end
          else        begin ev2[k] = v; if (h) eh1 = 1; end
        end
      end
    end
    nl1 = (eh1 && m_l1 > 0) ? m_l1 - 1 : m_l1;
    nl2 = (eh2 && m_l2 > 0) ? m_l2 - 1 : m_l2;
    ngo = m_go; nwin = m_win;
    if (nl1 == 0 || nl2 == 0) begin
      ngo = 1;
      nwin = (nl1 == 0 && nl2 == 0) ? 3 : (nl1 == 0) ? 2 : 1;
    end

    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    window_ok = 1; gv1 = '0; gv2 = '0; gh1 = 0; gh2 = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 21 && busy !== 1'b1) window_ok = 0;
      if (c == 22 && busy !== 1'b0) window_ok = 0;
      if (c == 21) begin
        gv1 = vanish_1; gv2 = vanish_2; gh1 = hit_1; gh2 = hit_2;
      end else if (vanish_1 !== '0 || vanish_2 !== '0 || hit_1 !== 1'b0 || hit_2 !== 1'b0) begin
        window_ok = 0;
      end
      if (c < 22) tick();
    end
    m_l1 = nl1; m_l2 = nl2; m_go = ngo; m_win = nwin;

    tests_run++;
    if (!window_ok) begin
      tests_failed++; $display("FAIL %s timing: busy/pulse window wrong (busy=%b at end)", name, busy);
    end
    tests_run++;
    if (gv1 !== ev1) begin tests_failed++; $display("FAIL %s vanish_1 got %b exp %b", name, gv1, ev1); end
    tests_run++;
    if (gv2 !== ev2) begin tests_failed++; $display("FAIL %s vanish_2 got %b exp %b", name, gv2, ev2); end
    tests_run++;
    if (gh1 !== eh1 || gh2 !== eh2) begin
      tests_failed++; $display("FAIL %s hit got %b%b exp %b%b", name, gh1, gh2, eh1, eh2);
    end
    tests_run++;
    if (lives_1 !== 2'(m_l1) || lives_2 !== 2'(m_l2)) begin
      tests_failed++; $display("FAIL %s lives got %0d/%0d exp %0d/%0d", name, lives_1, lives_2, m_l1, m_l2);
    end
    tests_run++;
    if (game_over !== m_go || winner !== 2'(m_win)) begin
      tests_failed++; $display("FAIL %s result got go=%b win=%0d exp go=%b win=%0d", name, game_over, winner, m_go, m_win);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (vanish_1 !== '0 || vanish_2 !== '0 || hit_1 !== 1'b0 || hit_2 !== 1'b0 || busy !== 1'b0 ||
        map_rd_addr !== 11'd0 || lives_1 !== 2'd3 || lives_2 !== 2'd3 || game_over !== 1'b0 || winner !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_values got v=%b/%b h=%b%b busy=%b addr=%0d lives=%0d/%0d go=%b win=%0d exp all zero, lives 3/3",
               vanish_1, vanish_2, hit_1, hit_2, busy, map_rd_addr, lives_1, lives_2, game_over, winner);
    end
    park_shells();
    run_scan("idle_scan");
  endtask

  task automatic test_oob();
    park_shells();
    set_shell(1, 2, 10, 63, 1);
    set_shell(1, 1, 39, 29, 1);
    set_shell(1, 4, 40, 0, 1);
    set_shell(2, 3, 0, 30, 1);
    run_scan("out_of_range");
  endtask

  task automatic test_wall();
    park_shells();
    set_shell(2, 0, 5, 5, 1);
    map_mem[5*MW + 5] = 1'b1;
    run_scan("wall_set");
    map_mem[5*MW + 5] = 1'b0;
    run_scan("wall_clear");
  endtask

  task automatic test_multi_hit();
    park_shells();
    tank_2_x_pos = 6'd20; tank_2_y_pos = 6'd12;
    set_shell(1, 0, 20, 12, 1);
    set_shell(1, 3, 20, 12, 1);
    set_shell(2, 1, 20, 12, 1);
    run_scan("multi_hit");
  endtask

  task automatic test_game_over();
    bit ok;
    apply_reset();
    clear_map();
    park_shells();
    tank_1_x_pos = 6'd3;  tank_1_y_pos = 6'd3;
    tank_2_x_pos = 6'd30; tank_2_y_pos = 6'd20;
    set_shell(1, 0, 30, 20, 1);
    set_shell(2, 4, 3, 3, 1);
    run_scan("mutual_1");
    run_scan("mutual_2");
    run_scan("mutual_3");
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    ok = 1;
    for (int c = 0; c < 25; c++) begin
      if (busy !== 1'b0 || vanish_1 !== '0 || vanish_2 !== '0 || lives_1 !== 2'd0 || lives_2 !== 2'd0) ok = 0;
      tick();
    end
    tests_run++;
    if (!ok || winner !== 2'd3 || game_over !== 1'b1) begin
      tests_failed++; $display("FAIL ignore_after_game_over busy=%b win=%0d go=%b exp busy 0 win 3 go 1", busy, winner, game_over);
    end
    apply_reset();
    park_shells();
    tank_2_x_pos = 6'd7; tank_2_y_pos = 6'd8;
    set_shell(1, 1, 7, 8, 1);
    for (int i = 0; i < 3; i++) run_scan("tank1_wins");
  endtask

  task automatic test_reset_abort();
    bit ok;
    apply_reset();
    park_shells();
    tank_2_x_pos = 6'd9; tank_2_y_pos = 6'd9;
    set_shell(1, 0, 9, 9, 1);
    set_shell(2, 2, 50, 1, 1);
    run_scan("pre_abort");
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || vanish_1 !== '0 || vanish_2 !== '0 || hit_2 !== 1'b0 || lives_2 !== 2'd3 ||
        map_rd_addr !== 11'd0 || game_over !== 1'b0) begin
      tests_failed++; $display("FAIL abort_values busy=%b v1=%b lives_2=%0d addr=%0d exp 0/0/3/0", busy, vanish_1, lives_2, map_rd_addr);
    end
    m_l1 = 3; m_l2 = 3; m_go = 1'b0; m_win = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    ok = 1;
    for (int c = 0; c < 25; c++) begin
      if (busy !== 1'b0 || vanish_1 !== '0 || vanish_2 !== '0) ok = 0;
      tick();
    end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL abort_no_partial busy=%b v1=%b exp idle, no vanish", busy, vanish_1); end
    run_scan("post_abort");
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int s = 0; s < 40; s++) begin
      if (m_go) apply_reset();
      clear_map();
      for (int i = 0; i < MW*MH; i++) map_mem[i] = ($urandom_range(0, 9) == 0);
      tank_1_x_pos = PW'($urandom_range(0, MW-1)); tank_1_y_pos = PW'($urandom_range(0, MH-1));
      tank_2_x_pos = PW'($urandom_range(0, MW-1)); tank_2_y_pos = PW'($urandom_range(0, MH-1));
      for (int t = 1; t <= 2; t++) begin
        for (int k = 0; k < NS; k++) begin
          r = $urandom_range(0, 9);
          if (r < 2)
            set_shell(t, k, $urandom_range(0, 63), $urandom_range(MH, 63), $urandom_range(0, 1));
          else if (r < 3)
            set_shell(t, k, $urandom_range(MW, 63), $urandom_range(0, MH-1), $urandom_range(0, 1));
          else if (r < 5)
            set_shell(t, k, (t == 1) ? int'(tank_2_x_pos) : int'(tank_1_x_pos),
                      (t == 1) ? int'(tank_2_y_pos) : int'(tank_1_y_pos), $urandom_range(0, 3) != 0);
          else
            set_shell(t, k, $urandom_range(0, MW-1), $urandom_range(0, MH-1), $urandom_range(0, 1));
        end
      end
      run_scan("random");
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b1; scan_start = 1'b0;
    clear_map();
    park_shells();
    apply_reset();
    test_reset();
    test_oob();
    test_wall();
    test_multi_hit();
    test_game_over();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
